// File: rtl/lpm_unpack.sv
// lpm_unpack: captures a packed bus of lpm_size words and emits them one word
// per accepted cycle, word 0 first, over a valid/ready stream.
// Ports:
//   clock, aclr_n  - clock and asynchronous active-low reset
//   sclr           - synchronous clear, aborts any packet in flight
//   data, load     - packed input packet and its valid
//   in_ready       - packet accepted when load & in_ready (combinational from ready)
//   result, valid  - current word and its valid (result is zero when idle)
//   ready          - downstream accept
//   index, last    - word number of result, and flag for the final word
module lpm_unpack #(
  parameter string       lpm_type  = "lpm_unpack",
  parameter int unsigned lpm_width = 1,
  parameter int unsigned lpm_size  = 1,
  parameter string       lpm_hint  = "UNUSED",
  localparam int unsigned IW = (lpm_size > 1) ? $clog2(lpm_size) : 1
) (
  input  logic                          clock,
  input  logic                          aclr_n,
  input  logic                          sclr,
  input  logic [lpm_size*lpm_width-1:0] data,
  input  logic                          load,
  output logic                          in_ready,
  output logic [lpm_width-1:0]          result,
  output logic                          valid,
  input  logic                          ready,
  output logic [IW-1:0]                 index,
  output logic                          last
);

  localparam int unsigned W  = lpm_width;
  localparam int unsigned N  = lpm_size;
  localparam int unsigned BW = N * W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [BW-1:0]   buf_q,   buf_d;
  logic            last_word;

  // State, index and packet buffer registers
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      index_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and stream outputs
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    result    = '0;
    last_word = (index_q == IW'(N - 1));

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (load) begin
          buf_d   = data;
          index_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        last  = last_word;
        // Word mux by constant slices keeps index widths exact for any size
        for (int j = 0; j < int'(N); j++) begin
          if (index_q == IW'(j)) result = buf_q[j*W +: W];
        end
        if (ready) begin
          if (last_word) begin
            // Final handshake frees the buffer in the same cycle: no bubble
            in_ready = 1'b1;
            index_d  = '0;
            if (load) buf_d   = data;
            else      state_d = IDLE;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over everything; a load in the same cycle is dropped
    if (sclr) begin
      state_d = IDLE;
      index_d = '0;
      buf_d   = buf_q;
    end
  end

  assign index = index_q;

endmodule

// File: tb/tb_lpm_unpack.sv
// Directed bench for lpm_unpack: a 4x8 instance for packet, backpressure,
// back-to-back and clear scenarios, plus a 1x4 instance for single-word packets.
module tb_lpm_unpack;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        sclr;
  logic [31:0] data;
  logic        load;
  logic        ready;
  logic        in_ready;
  logic [7:0]  result;
  logic        valid;
  logic [1:0]  index;
  logic        last;

  logic [3:0]  data1;
  logic        load1;
  logic        in_ready1;
  logic [3:0]  result1;
  logic        valid1;
  logic [0:0]  index1;
  logic        last1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  lpm_unpack #(.lpm_width(8), .lpm_size(4)) u_dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .load(load),
    .in_ready(in_ready), .result(result), .valid(valid), .ready(ready),
    .index(index), .last(last)
  );

  lpm_unpack #(.lpm_width(4), .lpm_size(1)) u_dut1 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data1), .load(load1),
    .in_ready(in_ready1), .result(result1), .valid(valid1), .ready(ready),
    .index(index1), .last(last1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] r, input logic [1:0] i,
                             input logic l, input logic ir);
    #1;
    chk({tag, ".valid"},    32'(valid),    32'd1);
    chk({tag, ".result"},   32'(result),   32'(r));
    chk({tag, ".index"},    32'(index),    32'(i));
    chk({tag, ".last"},     32'(last),     32'(l));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, ".valid"},    32'(valid),    32'd0);
    chk({tag, ".result"},   32'(result),   32'd0);
    chk({tag, ".index"},    32'(index),    32'd0);
    chk({tag, ".last"},     32'(last),     32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic       rdy_pat [7];
    logic [7:0] bp_res  [7];
    logic [1:0] bp_idx  [7];
    logic [7:0] b2b_res [8];
    logic [3:0] s1_res  [3];

    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bp_res  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
    bp_idx  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    b2b_res = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    s1_res  = '{4'hA, 4'hA, 4'h5};

    // Reset with a load asserted: must be ignored
    aclr_n = 1'b0; sclr = 1'b0; data = 32'h44332211; load = 1'b1; ready = 1'b1;
    data1 = 4'h0; load1 = 1'b0;
    expect_idle("reset");
    tick(); tick();
    expect_idle("reset_load");
    load = 1'b0;
    aclr_n = 1'b1;
    tick();

    // Basic packet
    data = 32'h44332211; load = 1'b1; ready = 1'b1;
    expect_idle("basic_pre");
    tick();
    load = 1'b0; data = 32'hDEADBEEF;
    expect_word("basic_w0", 8'h11, 2'd0, 1'b0, 1'b0); tick();
    expect_word("basic_w1", 8'h22, 2'd1, 1'b0, 1'b0); tick();
    expect_word("basic_w2", 8'h33, 2'd2, 1'b0, 1'b0); tick();
    expect_word("basic_w3", 8'h44, 2'd3, 1'b1, 1'b1); tick();
    expect_idle("basic_post");

    // Backpressure
    data = 32'h44332211; load = 1'b1; ready = 1'b0;
    tick();
    load = 1'b0; data = 32'h0;
    for (int k = 0; k < 7; k++) begin
      ready = rdy_pat[k];
      expect_word($sformatf("bp_%0d", k), bp_res[k], bp_idx[k], bp_idx[k] == 2'd3,
                  (bp_idx[k] == 2'd3) && rdy_pat[k]);
      tick();
    end
    expect_idle("bp_post");

    // Back-to-back packets with load held
    data = 32'h44332211; load = 1'b1; ready = 1'b1;
    tick();
    data = 32'hDDCCBBAA;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) load = 1'b0;
      expect_word($sformatf("b2b_%0d", k), b2b_res[k], 2'(k % 4), (k % 4) == 3, (k % 4) == 3);
      tick();
    end
    expect_idle("b2b_post");

    // Single-word packets, load every cycle
    data1 = 4'hA; load1 = 1'b1; ready = 1'b1;
    #1 chk("s1_pre.in_ready", 32'(in_ready1), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) data1 = 4'h5;
      #1;
      chk($sformatf("s1_%0d.valid", k),    32'(valid1),    32'd1);
      chk($sformatf("s1_%0d.result", k),   32'(result1),   32'(s1_res[k]));
      chk($sformatf("s1_%0d.index", k),    32'(index1),    32'd0);
      chk($sformatf("s1_%0d.last", k),     32'(last1),     32'd1);
      chk($sformatf("s1_%0d.in_ready", k), 32'(in_ready1), 32'd1);
      tick();
    end
    load1 = 1'b0;
    tick();
    chk("s1_post.valid",  32'(valid1),  32'd0);
    chk("s1_post.result", 32'(result1), 32'd0);

    // Synchronous clear at index 2, with a load that must be dropped
    data = 32'h44332211; load = 1'b1; ready = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    expect_word("sclr_pre", 8'h33, 2'd2, 1'b0, 1'b0);
    sclr = 1'b1; load = 1'b1; data = 32'h99887766;
    tick();
    sclr = 1'b0; load = 1'b0;
    expect_idle("sclr_post");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("sclr_quiet_%0d", k), 32'(valid), 32'd0);
    end
    data = 32'h0F0E0D0C; load = 1'b1;
    tick();
    load = 1'b0;
    expect_word("sclr_restart", 8'h0C, 2'd0, 1'b0, 1'b0);
    tick();
    expect_word("sclr_restart_w1", 8'h0D, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset while on the last word
    tick(); tick();
    expect_word("aclr_pre", 8'h0F, 2'd3, 1'b1, 1'b1);
    ready = 1'b0;
    #1 aclr_n = 1'b0;
    expect_idle("aclr_async");
    load = 1'b1; data = 32'h55443322;
    tick();
    expect_idle("aclr_held");
    aclr_n = 1'b1; load = 1'b0;
    tick();
    expect_idle("aclr_after");
    data = 32'h55443322; load = 1'b1; ready = 1'b1;
    tick();
    load = 1'b0;
    expect_word("aclr_restart", 8'h22, 2'd0, 1'b0, 1'b0);
    tick();
    expect_word("aclr_restart_w1", 8'h33, 2'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
